bcd_seq_conv: RTL and testbench

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one bit per clock instead of a combinational array of add-3 cells, so WIDTH and DIGITS can scale without growing a deep combinational path. It sits between binary datapath results (counters, ADC samples, arithmetic units) and display or formatting logic. Valid/ready handshakes on both sides make it backpressure-safe.

---
 rtl/bcd_seq_conv.sv | 137 +++++++++++++
 tb/tb_bcd_seq_conv.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A value accepted in IDLE is shifted MSB-first through the BCD digit register
// over WIDTH cycles. The result is then held in DONE until the downstream
// handshake completes. Digits beyond DIGITS are dropped, and a sticky flag
// records that the value did not fit.
module bcd_seq_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      binary_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
    logic [BW-1:0]   bcd_r;
    logic [BW-1:0]   bcd_s;
    logic [BW-1:0]   adj_s;
    logic            ovf_r;
    logic            ovf_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            last_step_s;

    // Per-digit correction: a digit of 5 or more becomes >= 8 after +3, so the
    // following left shift carries exactly one ten into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Apply the add-3 correction to every digit independently (no inter-digit carry).
    always_comb begin
        adj_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj_s[4*k +: 4] = add3(bcd_r[4*k +: 4]);
        end
    end

    assign last_step_s = (cnt_r == CW'(WIDTH - 1));

    // Next-state and datapath update for the IDLE / SHIFT / DONE sequence.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        bcd_s   = bcd_r;
        ovf_s   = ovf_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    shift_s = binary_in;
                    bcd_s   = '0;
                    ovf_s   = 1'b0;
                    cnt_s   = '0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // {ovf, bcd, shift} shifts left by one after correction.
                bcd_s   = {adj_s[BW-2:0], shift_r[WIDTH-1]};
                shift_s = shift_r << 1;
                ovf_s   = ovf_r | adj_s[BW-1];
                if (last_step_s) begin
                    cnt_s   = cnt_r;
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                shift_s = '0;
                bcd_s   = '0;
                ovf_s   = 1'b0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so no partial result is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            shift_r <= '0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            bcd_r   <= bcd_s;
            ovf_r   <= ovf_s;
            cnt_r   <= cnt_s;
        end
    end

    // Handshake flags decode straight from the state register, so no input reaches them combinationally.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bcd_out   = bcd_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed self-checking bench for bcd_seq_conv. Three instances cover
// the default (8,3), wide (16,5) and overflowing (8,2) configurations.
module tb_bcd_seq_conv;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_ovf;
    logic [15:0] w_bin;
    logic [19:0] w_bcd;

    logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_ovf;
    logic [7:0]  o_bin;
    logic [7:0]  o_bcd;

    int tests;
    int fails;

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .binary_in(a_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd_out(a_bcd), .out_ovf(a_ovf)
    );

    bcd_seq_conv #(.WIDTH(16), .DIGITS(5)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .binary_in(w_bin),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .bcd_out(w_bcd), .out_ovf(w_ovf)
    );

    bcd_seq_conv #(.WIDTH(8), .DIGITS(2)) u_ovf (
        .clk(clk), .rst_n(rst_n),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .binary_in(o_bin),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .bcd_out(o_bcd), .out_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic get_in_ready(input int sel);
        case (sel)
            0:       return a_in_ready;
            1:       return w_in_ready;
            default: return o_in_ready;
        endcase
    endfunction

    function automatic logic get_out_valid(input int sel);
        case (sel)
            0:       return a_out_valid;
            1:       return w_out_valid;
            default: return o_out_valid;
        endcase
    endfunction

    function automatic logic [19:0] get_res(input int sel);
        case (sel)
            0:       return {8'h00, a_bcd};
            1:       return w_bcd;
            default: return {12'h000, o_bcd};
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0:       return a_ovf;
            1:       return w_ovf;
            default: return o_ovf;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic vld, input logic [15:0] v);
        case (sel)
            0:       begin a_in_valid = vld; a_bin = v[7:0]; end
            1:       begin w_in_valid = vld; w_bin = v;      end
            default: begin o_in_valid = vld; o_bin = v[7:0]; end
        endcase
    endtask

    // Decimal reference for the 3-digit instance, independent of the shift algorithm.
    function automatic logic [11:0] ref3(input int n);
        logic [11:0] r;
        r[11:8] = 4'((n / 100) % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    // Offers v, counts edges from acceptance (inclusive) until out_valid is seen.
    // lat = -1 if the result never appears.
    task automatic run(input int sel, input logic [15:0] v,
                       output logic [19:0] res, output logic ovf, output int lat);
        int guard;
        guard = 0;
        res = 20'h0;
        ovf = 1'b0;
        @(negedge clk);
        while (!get_in_ready(sel) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        set_in(sel, 1'b1, v);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 16'h0000);
        lat = 1;
        while (!get_out_valid(sel) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!get_out_valid(sel)) begin
            lat = -1;
        end else begin
            res = get_res(sel);
            ovf = get_ovf(sel);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b expected 1/0", a_in_ready, a_out_valid);
        end
        tests++;
        if (a_bcd !== 12'h000 || a_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: bcd=%h ovf=%b expected 000/0", a_bcd, a_ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_scale;
        logic [19:0] r; logic f; int lat;
        run(0, 16'd255, r, f, lat);
        tests++;
        if (r[11:0] !== 12'h255 || f !== 1'b0) begin
            fails++;
            $display("FAIL full_scale: bcd=%h ovf=%b expected 255/0", r[11:0], f);
        end
        tests++;
        if (lat !== 9) begin
            fails++;
            $display("FAIL full_scale_latency: got %0d expected 9", lat);
        end
    endtask

    task automatic test_zero_sweep;
        logic [19:0] r; logic f; int lat;
        int sweep_bad;
        run(0, 16'd0, r, f, lat);
        tests++;
        if (r[11:0] !== 12'h000 || f !== 1'b0 || lat !== 9) begin
            fails++;
            $display("FAIL zero: bcd=%h ovf=%b lat=%0d expected 000/0/9", r[11:0], f, lat);
        end
        for (int n = 0; n < 256; n++) begin
            run(0, 16'(n), r, f, lat);
            sweep_bad = 0;
            for (int k = 0; k < 3; k++) begin
                if (r[4*k +: 4] > 4'd9) sweep_bad = 1;
            end
            tests++;
            if (r[11:0] !== ref3(n) || f !== 1'b0 || sweep_bad != 0) begin
                fails++;
                $display("FAIL sweep_%0d: bcd=%h ovf=%b expected %h/0", n, r[11:0], f, ref3(n));
            end
        end
    endtask

    task automatic test_wide;
        logic [19:0] r; logic f; int lat;
        run(1, 16'd65535, r, f, lat);
        tests++;
        if (r !== 20'h65535 || f !== 1'b0 || lat !== 17) begin
            fails++;
            $display("FAIL wide_65535: bcd=%h ovf=%b lat=%0d expected 65535/0/17", r, f, lat);
        end
        run(1, 16'd10000, r, f, lat);
        tests++;
        if (r !== 20'h10000 || f !== 1'b0 || lat !== 17) begin
            fails++;
            $display("FAIL wide_10000: bcd=%h ovf=%b lat=%0d expected 10000/0/17", r, f, lat);
        end
    endtask

    task automatic test_overflow;
        logic [19:0] r; logic f; int lat;
        run(2, 16'd100, r, f, lat);
        tests++;
        if (r[7:0] !== 8'h00 || f !== 1'b1) begin
            fails++;
            $display("FAIL ovf_100: bcd=%h ovf=%b expected 00/1", r[7:0], f);
        end
        run(2, 16'd99, r, f, lat);
        tests++;
        if (r[7:0] !== 8'h99 || f !== 1'b0) begin
            fails++;
            $display("FAIL ovf_99: bcd=%h ovf=%b expected 99/0", r[7:0], f);
        end
        run(2, 16'd255, r, f, lat);
        tests++;
        if (r[7:0] !== 8'h55 || f !== 1'b1) begin
            fails++;
            $display("FAIL ovf_255: bcd=%h ovf=%b expected 55/1", r[7:0], f);
        end
    endtask

    task automatic test_backpressure;
        logic [19:0] r; logic f; int lat;
        a_out_ready = 1'b0;
        run(0, 16'd200, r, f, lat);
        tests++;
        if (r[11:0] !== 12'h200 || lat !== 9) begin
            fails++;
            $display("FAIL bp_result: bcd=%h lat=%0d expected 200/9", r[11:0], lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (a_bcd !== 12'h200 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold_%0d: bcd=%h in_ready=%b out_valid=%b expected 200/0/1",
                         c, a_bcd, a_in_ready, a_out_valid);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_busy_ignore;
        int guard;
        @(negedge clk);
        set_in(0, 1'b1, 16'd42);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        set_in(0, 1'b1, 16'd77);
        tests++;
        if (a_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready: in_ready=%b expected 0", a_in_ready);
        end
        @(negedge clk);
        set_in(0, 1'b0, 16'h0000);
        guard = 0;
        while (!a_out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (a_out_valid !== 1'b1 || a_bcd !== 12'h042 || a_ovf !== 1'b0) begin
            fails++;
            $display("FAIL busy_result: out_valid=%b bcd=%h ovf=%b expected 1/042/0", a_out_valid, a_bcd, a_ovf);
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] r; logic f; int lat;
        @(negedge clk);
        while (!a_in_ready) @(negedge clk);
        set_in(0, 1'b1, 16'd123);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_bcd !== 12'h000 || a_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: in_ready=%b out_valid=%b bcd=%h ovf=%b expected 1/0/000/0",
                     a_in_ready, a_out_valid, a_bcd, a_ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 16'd128, r, f, lat);
        tests++;
        if (r[11:0] !== 12'h128 || f !== 1'b0 || lat !== 9) begin
            fails++;
            $display("FAIL reset_mid_after: bcd=%h ovf=%b lat=%0d expected 128/0/9", r[11:0], f, lat);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        a_in_valid = 1'b0; a_bin = 8'h00;  a_out_ready = 1'b1;
        w_in_valid = 1'b0; w_bin = 16'h0000; w_out_ready = 1'b1;
        o_in_valid = 1'b0; o_bin = 8'h00;  o_out_ready = 1'b1;

        test_reset();
        test_full_scale();
        test_zero_sweep();
        test_wide();
        test_overflow();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
